tt_eval_unit: RTL and testbench

- Programmable, registered successor to the fixed 4-in/4-out product-of-sums logic blocks: an IN_W-input, OUT_W-output truth table held in internal storage.
- Loaded serially over a config stream, then evaluated over a valid/ready stream with one result per cycle.
- Sits between switch/stimulus logic and display/LED logic, so one bitstream can realise any lab function without re-synthesis.

---
 rtl/tt_pkg.sv | 19 +
 rtl/tt_eval_unit_if.sv | 28 ++
 rtl/tt_store.sv | 27 ++
 rtl/tt_eval_unit.sv | 105 ++++++++++
 tb/tb_tt_eval_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/tt_pkg.sv
// Shared types and helpers for the programmable truth-table evaluator.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } tt_state_e;

  function automatic int TT_DEPTH(input int in_w);
    return 2 ** in_w;
  endfunction

  // Even parity: the returned bit makes the XOR over data plus parity zero.
  function automatic logic tt_even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tt_eval_unit_if.sv
// Config, evaluate and result streams of tt_eval_unit bundled as one interface.
interface tt_eval_unit_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 4
);
  logic             cfg_start;
  logic             cfg_valid;
  logic [OUT_W-1:0] cfg_data;
  logic             cfg_ready;
  logic             in_valid;
  logic [IN_W-1:0]  in_x;
  logic             in_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_y;
  logic             out_ready;
  logic             out_err;
  logic             loaded;

  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, in_x, out_ready,
    input  cfg_ready, in_ready, out_valid, out_y, out_err, loaded
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, in_valid, in_x, out_ready,
    output cfg_ready, in_ready, out_valid, out_y, out_err, loaded
  );
endinterface

// File: rtl/tt_store.sv
// Truth-table storage: simple dual port, synchronous write, combinational read.
module tt_store
  import tt_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = TT_DEPTH(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto distributed RAM; contents are
  // meaningless until a full load completes, which the loaded flag tracks.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tt_eval_unit.sv
// Programmable IN_W-in / OUT_W-out truth table: serial load, 1-cycle registered lookup.
// Optional macro TT_PARITY_EN adds a per-entry even-parity bit and drives out_err.
module tt_eval_unit
  import tt_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 4
) (
  input logic           clk,
  input logic           rst,
  tt_eval_unit_if.slave bus
);
  localparam int DEPTH = TT_DEPTH(IN_W);
`ifdef TT_PARITY_EN
  localparam int ENTRY_W = OUT_W + 1;
`else
  localparam int ENTRY_W = OUT_W;
`endif

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_RUN  = RUN;

  localparam logic [IN_W-1:0] LAST_ADDR = IN_W'(DEPTH - 1);

  logic [1:0]         state;
  logic [IN_W-1:0]    addr;
  logic               loaded_q;
  logic               out_valid_q;
  logic [OUT_W-1:0]   out_y_q;
  logic               out_err_q;
  logic               cfg_fire;
  logic               in_fire;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic               rd_err;

  assign bus.cfg_ready = (state == S_LOAD);
  // A restart in RUN must not let a new input slip in during the start cycle.
  assign bus.in_ready  = (state == S_RUN) && !bus.cfg_start &&
                         (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_err   = out_err_q;
  assign bus.loaded    = loaded_q;

  assign cfg_fire = bus.cfg_valid && (state == S_LOAD) && !bus.cfg_start;
  assign in_fire  = bus.in_valid && bus.in_ready;

`ifdef TT_PARITY_EN
  assign wr_entry = {tt_even_parity(32'(bus.cfg_data)), bus.cfg_data};
  assign rd_err   = tt_even_parity(32'(rd_entry[OUT_W-1:0])) != rd_entry[OUT_W];
`else
  assign wr_entry = bus.cfg_data;
  assign rd_err   = 1'b0;
`endif

  tt_store #(
    .ADDR_W(IN_W),
    .DATA_W(ENTRY_W)
  ) u_store (
    .clk  (clk),
    .we   (cfg_fire),
    .waddr(addr),
    .wdata(wr_entry),
    .raddr(bus.in_x),
    .rdata(rd_entry)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of the order the always_ff blocks evaluate in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      addr     <= '0;
      loaded_q <= 1'b0;
    end else if (bus.cfg_start) begin
      state    <= S_LOAD;
      addr     <= '0;
      loaded_q <= 1'b0;
    end else if (cfg_fire) begin
      addr <= addr + 1'b1;
      if (addr == LAST_ADDR) begin
        state    <= S_RUN;
        loaded_q <= 1'b1;
      end
    end
  end

  // Result register: holds under backpressure, drains even while reloading.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_err_q   <= 1'b0;
    end else if (in_fire) begin
      out_valid_q <= 1'b1;
      out_y_q     <= rd_entry[OUT_W-1:0];
      out_err_q   <= rd_err;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tt_eval_unit.sv
// Directed self-checking bench for tt_eval_unit (IN_W=4, OUT_W=4).
module tb_tt_eval_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  tt_eval_unit_if #(.IN_W(4), .OUT_W(4)) bus ();

  tt_eval_unit #(.IN_W(4), .OUT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Loads 16 entries (identity or inverted), optionally issuing cfg_start and
  // inserting idle gaps; checks loaded rises exactly after the 16th write.
  task automatic load_table(input bit ident, input bit gaps, input bit do_start);
    if (do_start) begin
      bus.cfg_start = 1'b1;
      tick();
      bus.cfg_start = 1'b0;
    end
    check1("load_cfg_ready", bus.cfg_ready, 1'b1);
    check1("load_in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 16; i++) begin
      bus.cfg_valid = 1'b0;
      if (gaps && (i % 3 == 1)) tick();
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = ident ? 4'(i) : 4'(15 - i);
      if (i == 15) check1("loaded_before_last", bus.loaded, 1'b0);
      tick();
    end
    bus.cfg_valid = 1'b0;
    check1("loaded_after_last", bus.loaded, 1'b1);
    check1("cfg_ready_in_run", bus.cfg_ready, 1'b0);
  endtask

  task automatic eval(input logic [3:0] x, input logic [3:0] exp_y, input logic exp_err);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    #1;
    check1("eval_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check1("eval_out_valid", bus.out_valid, 1'b1);
    check4($sformatf("eval_out_y_x%0d", x), bus.out_y, exp_y);
    check1($sformatf("eval_out_err_x%0d", x), bus.out_err, exp_err);
  endtask

  initial begin
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.out_ready = 1'b0;

    tick();
    tick();
    rst = 1'b0;
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check1("rst_loaded", bus.loaded, 1'b0);
    check1("rst_in_ready", bus.in_ready, 1'b0);
    check1("rst_cfg_ready", bus.cfg_ready, 1'b0);
    check4("rst_out_y", bus.out_y, 4'h0);
    check1("rst_out_err", bus.out_err, 1'b0);

    // Inputs before any load are ignored.
    bus.in_valid = 1'b1;
    bus.in_x     = 4'h3;
    for (int i = 0; i < 10; i++) begin
      tick();
      check1("idle_in_ready", bus.in_ready, 1'b0);
      check1("idle_out_valid", bus.out_valid, 1'b0);
      check1("idle_loaded", bus.loaded, 1'b0);
    end
    bus.in_valid = 1'b0;

    // Inverted table with gaps, then a back-to-back sweep.
    load_table(1'b0, 1'b1, 1'b1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) eval(4'(i), 4'(15 - i), 1'b0);
    tick();
    check1("drain_out_valid", bus.out_valid, 1'b0);

    // Backpressure holds the result and blocks new inputs.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_x      = 4'h5;
    tick();
    bus.in_x = 4'h6;
    for (int i = 0; i < 3; i++) begin
      #1;
      check1("bp_in_ready", bus.in_ready, 1'b0);
      check1("bp_out_valid", bus.out_valid, 1'b1);
      check4("bp_out_y", bus.out_y, 4'hA);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check1("bp_release_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check1("bp_next_valid", bus.out_valid, 1'b1);
    check4("bp_next_y", bus.out_y, 4'h9);
    tick();

    // Restart after 7 writes; the cfg_valid coinciding with cfg_start is dropped.
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = 4'hF;
      tick();
    end
    bus.cfg_start = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 4'h3;
    tick();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    check1("restart_loaded", bus.loaded, 1'b0);
    load_table(1'b1, 1'b0, 1'b0);
    eval(4'hC, 4'hC, 1'b0);
    eval(4'h0, 4'h0, 1'b0);
    eval(4'hF, 4'hF, 1'b0);
    tick();

    // Restart while a result is stalled: result survives until consumed.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_x      = 4'h9;
    tick();
    bus.in_valid  = 1'b0;
    bus.cfg_start = 1'b1;
    #1;
    check1("start_cycle_in_ready", bus.in_ready, 1'b0);
    tick();
    bus.cfg_start = 1'b0;
    check1("reload_cfg_ready", bus.cfg_ready, 1'b1);
    check1("reload_loaded", bus.loaded, 1'b0);
    check1("reload_out_valid", bus.out_valid, 1'b1);
    check4("reload_out_y", bus.out_y, 4'h9);
    bus.in_valid = 1'b1;
    bus.in_x     = 4'h2;
    tick();
    check1("reload_in_ready", bus.in_ready, 1'b0);
    check4("reload_hold_y", bus.out_y, 4'h9);
    bus.out_ready = 1'b1;
    tick();
    check1("reload_consumed", bus.out_valid, 1'b0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = 4'(i);
      tick();
    end
    bus.cfg_valid = 1'b0;
    check1("partial_loaded", bus.loaded, 1'b0);

    // Reset mid-load returns to idle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("midload_rst_cfg_ready", bus.cfg_ready, 1'b0);
    check1("midload_rst_loaded", bus.loaded, 1'b0);
    check1("midload_rst_in_ready", bus.in_ready, 1'b0);
    check1("midload_rst_out_valid", bus.out_valid, 1'b0);

    // Parity: corrupt entry 3 after loading the identity table.
    load_table(1'b1, 1'b0, 1'b1);
`ifdef TT_PARITY_EN
    dut.u_store.mem[3][0] = ~dut.u_store.mem[3][0];
    eval(4'h3, 4'h2, 1'b1);
    eval(4'h4, 4'h4, 1'b0);
`else
    eval(4'h3, 4'h3, 1'b0);
    eval(4'h4, 4'h4, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
